// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC fine-time path.
//   TDC_TAPS_DEFAULT / TDC_HIST_DEFAULT : default chain length and history depth
//   TDC_MAX_TAPS                        : widest snapshot the encode helpers accept
//   tdc_hist_t                          : {code, bubble} entry at the default tap count
//   popcount(t) / bubble(t)             : snapshot encoders (t zero-extended to TDC_MAX_TAPS)
package tdc_pkg;

  localparam int TDC_TAPS_DEFAULT = 64;
  localparam int TDC_HIST_DEFAULT = 8;
  localparam int TDC_MAX_TAPS     = 256;
  localparam int TDC_CODE_W       = $clog2(TDC_TAPS_DEFAULT + 1);

  typedef struct packed {
    logic [TDC_CODE_W-1:0] code;
    logic                  bubble;
  } tdc_hist_t;

  // Number of ones in the normalised snapshot.
  function automatic int unsigned popcount(input logic [TDC_MAX_TAPS-1:0] t);
    int unsigned n;
    n = 0;
    for (int i = 0; i < TDC_MAX_TAPS; i++) begin
      n += {31'd0, t[i]};
    end
    return n;
  endfunction

  // A monotone snapshot is a run of ones from tap 0 followed by zeros.
  // Any 0->1 step moving up the chain is a bubble. Zero padding above
  // the real taps can never create one.
  function automatic logic bubble(input logic [TDC_MAX_TAPS-1:0] t);
    logic b;
    b = 1'b0;
    for (int i = 0; i < TDC_MAX_TAPS - 1; i++) begin
      b |= t[i+1] & ~t[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/tdc_carry_chain.sv
// Carry-chain delay line for the TDC interpolator.
//   signal_in : raw input, enters the chain at tap 0
//   taps      : taps[i] = carry[i+1], one bit per chain stage
// On iCE40 builds (ICE40_PRIMITIVES defined) each stage is an SB_CARRY
// with I0=1, I1=0, so CO = CI and the chain is a pure propagation delay.
// Otherwise the chain collapses to zero delay: every tap equals signal_in.
module tdc_carry_chain #(
  parameter int TAPS = 64
) (
  input  logic            signal_in,
  output logic [TAPS-1:0] taps
);

`ifdef ICE40_PRIMITIVES
  logic [TAPS:0] carry;

  assign carry[0] = signal_in;

  for (genvar i = 0; i < TAPS; i++) begin : g_stage
    (* keep *) SB_CARRY u_carry (
      .CO (carry[i+1]),
      .I0 (1'b1),
      .I1 (1'b0),
      .CI (carry[i])
    );
  end

  assign taps = carry[TAPS:1];
`else
  assign taps = {TAPS{signal_in}};
`endif

endmodule

// File: rtl/tdc_fine_capture.sv
// Fine-time interpolator: carry-chain snapshot -> 2-flop sync -> encode ->
// history shift register -> lag-selected capture on `sample`.
//   clk, rst_n              : sampling clock, async active-low reset
//   signal_in               : raw input into the carry chain
//   sample, lag_sel         : capture strobe and history entry to return
//   edge_pol                : 0 rising, 1 falling (inverts snapshot before encode)
//   fine_valid/ready/count  : output register and handshake
//   fine_bubble             : captured snapshot was non-monotone
//   overflow                : sticky, a sample arrived while output was blocked
//   cal_en, clear           : statistics enable and clear (clear wins)
//   code_min/max, sample_cnt: calibration statistics of loaded codes
//
// Handshake: a code transfers on any cycle with fine_valid & fine_ready.
// fine_valid then clears unless a sample loads a new code in that same
// cycle. A sample that finds fine_valid & !fine_ready is dropped, the held
// code is untouched, and overflow is set.
module tdc_fine_capture
  import tdc_pkg::*;
#(
  parameter int TAPS       = TDC_TAPS_DEFAULT,
  parameter int HIST_DEPTH = TDC_HIST_DEFAULT,
  parameter int CNT_W      = $clog2(TAPS + 1),
  parameter int LAG_W      = $clog2(HIST_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             signal_in,
  input  logic             sample,
  input  logic             edge_pol,
  input  logic [LAG_W-1:0] lag_sel,
  input  logic             fine_ready,
  output logic             fine_valid,
  output logic [CNT_W-1:0] fine_count,
  output logic             fine_bubble,
  output logic             overflow,
  input  logic             cal_en,
  input  logic             clear,
  output logic [CNT_W-1:0] code_min,
  output logic [CNT_W-1:0] code_max,
  output logic [15:0]      sample_cnt
);

  typedef struct packed {
    logic [CNT_W-1:0] code;
    logic             bubble;
  } hist_entry_t;

  logic [TAPS-1:0] chain_taps;
  logic [TAPS-1:0] tap_q;
  logic [TAPS-1:0] tap_qq;
  logic [TAPS-1:0] tap_norm;
  logic [CNT_W-1:0] enc_code;
  logic            enc_bubble;
  hist_entry_t     hist [HIST_DEPTH];
  hist_entry_t     hist_sel;
  logic            load;
  logic            drop;
  logic            transfer;

  tdc_carry_chain #(.TAPS(TAPS)) u_chain (
    .signal_in (signal_in),
    .taps      (chain_taps)
  );

  // signal_in is asynchronous; two flops before any logic looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q  <= '0;
      tap_qq <= '0;
    end else begin
      tap_q  <= chain_taps;
      tap_qq <= tap_q;
    end
  end

  assign tap_norm = edge_pol ? ~tap_qq : tap_qq;

  always_comb begin
    enc_code   = CNT_W'(popcount(TDC_MAX_TAPS'(tap_norm)));
    enc_bubble = bubble(TDC_MAX_TAPS'(tap_norm));
  end

  // Entries are stored already encoded, so an edge_pol change only
  // affects snapshots encoded after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < HIST_DEPTH; j++) hist[j] <= '0;
    end else begin
      hist[0] <= '{code: enc_code, bubble: enc_bubble};
      for (int j = 1; j < HIST_DEPTH; j++) hist[j] <= hist[j-1];
    end
  end

  assign hist_sel = hist[lag_sel];
  assign transfer = fine_valid & fine_ready;
  assign load     = sample & (~fine_valid | fine_ready);
  assign drop     = sample & fine_valid & ~fine_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fine_valid  <= 1'b0;
      fine_count  <= '0;
      fine_bubble <= 1'b0;
    end else if (load) begin
      fine_valid  <= 1'b1;
      fine_count  <= hist_sel.code;
      fine_bubble <= hist_sel.bubble;
    end else if (transfer) begin
      fine_valid  <= 1'b0;
    end
  end

  // clear outranks everything, including a load in the same cycle: that
  // code still reaches the output register but is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      code_min   <= CNT_W'(TAPS);
      code_max   <= '0;
      sample_cnt <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      code_min   <= CNT_W'(TAPS);
      code_max   <= '0;
      sample_cnt <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (load && cal_en) begin
        if (hist_sel.code < code_min) code_min <= hist_sel.code;
        if (hist_sel.code > code_max) code_max <= hist_sel.code;
        if (sample_cnt != 16'hFFFF) sample_cnt <= sample_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_tdc_fine_capture.sv
module tb_tdc_fine_capture;
  import tdc_pkg::*;

  localparam int TAPS       = TDC_TAPS_DEFAULT;
  localparam int HIST_DEPTH = TDC_HIST_DEFAULT;
  localparam int CNT_W      = 7;
  localparam int LAG_W      = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             signal_in  = 1'b0;
  logic             sample     = 1'b0;
  logic             edge_pol   = 1'b0;
  logic [LAG_W-1:0] lag_sel    = 3'd1;
  logic             fine_ready = 1'b1;
  logic             cal_en     = 1'b0;
  logic             clear      = 1'b0;
  logic             fine_valid;
  logic [CNT_W-1:0] fine_count;
  logic             fine_bubble;
  logic             overflow;
  logic [CNT_W-1:0] code_min;
  logic [CNT_W-1:0] code_max;
  logic [15:0]      sample_cnt;

  logic [TAPS-1:0]  tap_pat;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_q [$];

  tdc_fine_capture #(
    .TAPS(TAPS), .HIST_DEPTH(HIST_DEPTH), .CNT_W(CNT_W), .LAG_W(LAG_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .signal_in  (signal_in),
    .sample     (sample),
    .edge_pol   (edge_pol),
    .lag_sel    (lag_sel),
    .fine_ready (fine_ready),
    .fine_valid (fine_valid),
    .fine_count (fine_count),
    .fine_bubble(fine_bubble),
    .overflow   (overflow),
    .cal_en     (cal_en),
    .clear      (clear),
    .code_min   (code_min),
    .code_max   (code_max),
    .sample_cnt (sample_cnt)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task set_taps(input logic [TAPS-1:0] v);
    tap_pat = v;
    force dut.chain_taps = tap_pat;
  endtask

  function automatic logic [TAPS-1:0] ones(input int k);
    logic [TAPS-1:0] v;
    v = '0;
    for (int i = 0; i < k; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic settle();
    repeat (12) tick();
  endtask

  task automatic capture(input logic [LAG_W-1:0] lag);
    lag_sel = lag;
    sample  = 1'b1;
    tick();
    sample  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"},  32'(fine_valid),  32'd0);
    check_eq({tag, "_count"},  32'(fine_count),  32'd0);
    check_eq({tag, "_bubble"}, 32'(fine_bubble), 32'd0);
    check_eq({tag, "_ovf"},    32'(overflow),    32'd0);
    check_eq({tag, "_min"},    32'(code_min),    32'd64);
    check_eq({tag, "_max"},    32'(code_max),    32'd0);
    check_eq({tag, "_cnt"},    32'(sample_cnt),  32'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    set_taps('0);
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    settle();

    // Rising edge, 32 ones sampled from edge 0; sample at edge 4 with lag 1.
    set_taps(64'h0000_0000_FFFF_FFFF);
    repeat (4) tick();
    capture(3'd1);
    check_eq("rise32_count",  32'(fine_count),  32'd32);
    check_eq("rise32_bubble", 32'(fine_bubble), 32'd0);
    check_eq("rise32_valid",  32'(fine_valid),  32'd1);
    tick();
    check_eq("rise32_drain",  32'(fine_valid),  32'd0);

    // Falling edge and full-scale codes.
    edge_pol = 1'b1;
    set_taps(64'hFFFF_FFFF_FFFF_FF00);
    settle();
    capture(3'd1);
    check_eq("fall8_count", 32'(fine_count), 32'd8);
    set_taps({TAPS{1'b1}});
    settle();
    capture(3'd1);
    check_eq("fall_all1_count", 32'(fine_count), 32'd0);
    edge_pol = 1'b0;
    settle();
    capture(3'd1);
    check_eq("rise_all1_count",  32'(fine_count),  32'd64);
    check_eq("rise_all1_bubble", 32'(fine_bubble), 32'd0);

    // Lag sweep: k ones sampled at relative edge k. A sample before edge k
    // with lag L returns k-3-L ones.
    for (int k = 0; k <= 24; k++) begin
      set_taps(ones(k));
      if (k >= 10 && (k % 2) == 0) begin
        lag_sel = 3'((k - 10) / 2);
        sample  = 1'b1;
        exp_q.push_back(CNT_W'(k - 3 - (k - 10) / 2));
      end
      tick();
      if (sample) begin
        sample = 1'b0;
        check_eq($sformatf("lag%0d_count", lag_sel), 32'(fine_count), 32'(exp_q.pop_front()));
      end
    end

    // Bubble: 0xF7 has a hole at bit 3.
    set_taps(64'h0000_0000_0000_00F7);
    settle();
    capture(3'd1);
    check_eq("bubble_count", 32'(fine_count),  32'd7);
    check_eq("bubble_flag",  32'(fine_bubble), 32'd1);
    tick();

    // Backpressure.
    set_taps(ones(5));
    settle();
    fine_ready = 1'b0;
    capture(3'd1);
    check_eq("bp_first_valid", 32'(fine_valid), 32'd1);
    check_eq("bp_first_count", 32'(fine_count), 32'd5);
    check_eq("bp_first_ovf",   32'(overflow),   32'd0);
    set_taps(ones(9));
    settle();
    capture(3'd1);
    check_eq("bp_drop_count", 32'(fine_count), 32'd5);
    check_eq("bp_drop_valid", 32'(fine_valid), 32'd1);
    check_eq("bp_drop_ovf",   32'(overflow),   32'd1);
    set_taps(ones(12));
    settle();
    fine_ready = 1'b1;
    capture(3'd1);
    check_eq("bp_xfer_load_count", 32'(fine_count), 32'd12);
    check_eq("bp_xfer_load_valid", 32'(fine_valid), 32'd1);
    tick();
    check_eq("bp_drained_valid", 32'(fine_valid), 32'd0);
    check_eq("bp_ovf_sticky",    32'(overflow),   32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("bp_clear_ovf", 32'(overflow), 32'd0);

    // Statistics stay idle while cal_en is low.
    check_eq("cal_off_min", 32'(code_min),   32'd64);
    check_eq("cal_off_cnt", 32'(sample_cnt), 32'd0);

    // Calibration: codes 10, 50, 30.
    cal_en = 1'b1;
    set_taps(ones(10)); settle(); capture(3'd1);
    set_taps(ones(50)); settle(); capture(3'd1);
    set_taps(ones(30)); settle(); capture(3'd1);
    check_eq("cal_min", 32'(code_min),   32'd10);
    check_eq("cal_max", 32'(code_max),   32'd50);
    check_eq("cal_cnt", 32'(sample_cnt), 32'd3);

    // clear together with a sample: output loads, statistics reset.
    set_taps(ones(20));
    settle();
    clear = 1'b1;
    capture(3'd1);
    clear = 1'b0;
    check_eq("clr_smp_count", 32'(fine_count), 32'd20);
    check_eq("clr_smp_valid", 32'(fine_valid), 32'd1);
    check_eq("clr_smp_min",   32'(code_min),   32'd64);
    check_eq("clr_smp_max",   32'(code_max),   32'd0);
    check_eq("clr_smp_cnt",   32'(sample_cnt), 32'd0);
    tick();

    // Dropped samples are not counted.
    set_taps(ones(40));
    settle();
    fine_ready = 1'b0;
    capture(3'd1);
    capture(3'd0);
    check_eq("drop_nocount_cnt", 32'(sample_cnt), 32'd1);
    check_eq("drop_nocount_min", 32'(code_min),   32'd40);
    check_eq("drop_nocount_max", 32'(code_max),   32'd40);
    check_eq("drop_nocount_ovf", 32'(overflow),   32'd1);

    // Asynchronous reset mid-cycle, outputs must drop without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    #1;
    rst_n = 1'b1;
    fine_ready = 1'b1;
    // Edges after release: 0 -> tap_q, 1 -> tap_qq, 2 -> history[0].
    repeat (2) tick();
    capture(3'd0);
    check_eq("post_rst_early", 32'(fine_count), 32'd0);
    capture(3'd0);
    check_eq("post_rst_first", 32'(fine_count), 32'd40);

    release dut.chain_taps;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
